// File: rtl/exe_wb_scheduler.sv
// Writeback-port scheduler for the EXE stage: reserves the single regfile write slot
// at each op's fixed latency, stalls issue on slot/WAW conflicts, and answers RAW queries.
module exe_wb_scheduler #(
    parameter int unsigned LAT_ALU  = 1,
    parameter int unsigned LAT_MEM  = 2,
    parameter int unsigned LAT_VDOT = 3,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       issue_op,
    input  logic [4:0]       issue_rd,
    input  logic             issue_regwrite,
    input  logic             flush,
    output logic             issue_ready,
    output logic             stall,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [1:0]       wb_sel,
    input  logic [4:0]       q_rs1,
    input  logic [4:0]       q_rs2,
    output logic             q_hazard1,
    output logic             q_hazard2,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_VDOT = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        wb_sel_e    sel;
    } entry_t;

    // tab_q[i] is the writeback that happens i cycles from now; index 0 drives wb_*.
    entry_t           tab_q [DEPTH];
    entry_t           tab_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    int unsigned lat;
    wb_sel_e     sel_new;
    logic        need_slot;
    logic        slot_busy;
    logic        waw;

    always_comb begin
        lat     = LAT_ALU;
        sel_new = SEL_ALU;
        unique case (issue_op)
            2'd1: begin
                lat     = LAT_MEM;
                sel_new = SEL_MEM;
            end
            2'd2: begin
                lat     = LAT_VDOT;
                sel_new = SEL_VDOT;
            end
            default: begin
                lat     = LAT_ALU;
                sel_new = SEL_ALU;
            end
        endcase
        need_slot = issue_regwrite & (issue_rd != 5'd0);
    end

    // Slot conflict looks at index lat because that entry shifts into lat-1 at the edge.
    always_comb begin
        slot_busy = 1'b0;
        waw       = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (j == lat && tab_q[j].valid)
                slot_busy = 1'b1;
            if (j > lat && tab_q[j].valid && tab_q[j].rd == issue_rd)
                waw = 1'b1;
        end
        issue_ready = issue_valid & ~flush & (~need_slot | (~slot_busy & ~waw));
        stall       = issue_valid & ~issue_ready & ~flush;
    end

    always_comb begin
        q_hazard1 = 1'b0;
        q_hazard2 = 1'b0;
        busy      = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy = busy | tab_q[i].valid;
            if (i >= 1 && tab_q[i].valid && tab_q[i].rd == q_rs1 && q_rs1 != 5'd0)
                q_hazard1 = 1'b1;
            if (i >= 1 && tab_q[i].valid && tab_q[i].rd == q_rs2 && q_rs2 != 5'd0)
                q_hazard2 = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < DEPTH - 1; j++)
            tab_d[j] = tab_q[j+1];
        tab_d[DEPTH-1] = '0;
        if (issue_ready && need_slot) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j + 1 == lat) begin
                    tab_d[j].valid = 1'b1;
                    tab_d[j].rd    = issue_rd;
                    tab_d[j].sel   = sel_new;
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        issue_cnt_d = issue_cnt_q;
        if (issue_ready && issue_cnt_q != '1)
            issue_cnt_d = issue_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                tab_q[i] <= '0;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            tab_q       <= tab_d;
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign wb_valid  = tab_q[0].valid;
    assign wb_rd     = tab_q[0].rd;
    assign wb_sel    = tab_q[0].sel;
    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_exe_wb_scheduler.sv
// Bench for exe_wb_scheduler: a pending-writeback list keyed by absolute cycle number
// predicts every output; directed scenarios plus randomized issue traffic.
module tb_exe_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [4:0]  issue_rd;
    logic        issue_regwrite;
    logic        flush;
    logic        issue_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        q_hazard1;
    logic        q_hazard2;
    logic        busy;
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;

    exe_wb_scheduler #(
        .LAT_ALU (1),
        .LAT_MEM (2),
        .LAT_VDOT(3),
        .DEPTH   (4),
        .CNT_W   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_rd      (issue_rd),
        .issue_regwrite(issue_regwrite),
        .flush         (flush),
        .issue_ready   (issue_ready),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_sel        (wb_sel),
        .q_rs1         (q_rs1),
        .q_rs2         (q_rs2),
        .q_hazard1     (q_hazard1),
        .q_hazard2     (q_hazard2),
        .busy          (busy),
        .stall_cnt     (stall_cnt),
        .issue_cnt     (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tgt;
        logic [4:0] rd;
        logic [1:0] sel;
    } pend_t;

    pend_t pend[$];
    int    cyc;
    int    total;
    int    bad;
    int    m_stall_cnt;
    int    m_issue_cnt;

    // Model outputs from the most recent cycle, used by the literal pins.
    logic       m_ready, m_stall, m_wbv, m_hz1, m_hz2;
    logic [4:0] m_wbrd;
    logic [1:0] m_wbsel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    // Called at posedge+1; presents one request, checks at negedge, returns at next posedge+1.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [4:0] rd,
                         input logic rw, input logic fl, input logic [4:0] qa, input logic [4:0] qb);
        int         lat;
        logic [1:0] sel;
        logic       w, taken, wawm, bsy;
        pend_t      keep[$];
        issue_valid    = v;
        issue_op       = op;
        issue_rd       = rd;
        issue_regwrite = rw;
        flush          = fl;
        q_rs1          = qa;
        q_rs2          = qb;
        @(negedge clk);
        lat = (op == 2'd1) ? 2 : (op == 2'd2) ? 3 : 1;
        sel = (op == 2'd1) ? 2'd1 : (op == 2'd2) ? 2'd2 : 2'd0;
        w   = rw && (rd != 5'd0);
        taken = 1'b0; wawm = 1'b0; bsy = 1'b0;
        m_wbv = 1'b0; m_wbrd = 5'd0; m_wbsel = 2'd0; m_hz1 = 1'b0; m_hz2 = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].tgt == cyc + lat) taken = 1'b1;
            if (pend[i].tgt > cyc + lat && pend[i].rd == rd) wawm = 1'b1;
            if (pend[i].tgt >= cyc) bsy = 1'b1;
            if (pend[i].tgt == cyc) begin
                m_wbv = 1'b1; m_wbrd = pend[i].rd; m_wbsel = pend[i].sel;
            end
            if (pend[i].tgt > cyc && pend[i].rd == qa && qa != 5'd0) m_hz1 = 1'b1;
            if (pend[i].tgt > cyc && pend[i].rd == qb && qb != 5'd0) m_hz2 = 1'b1;
        end
        m_ready = v && !fl && (!w || (!taken && !wawm));
        m_stall = v && !m_ready && !fl;

        check("issue_ready", {31'd0, issue_ready}, {31'd0, m_ready});
        check("stall", {31'd0, stall}, {31'd0, m_stall});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, m_wbv});
        if (m_wbv) begin
            check("wb_rd", {27'd0, wb_rd}, {27'd0, m_wbrd});
            check("wb_sel", {30'd0, wb_sel}, {30'd0, m_wbsel});
        end
        check("q_hazard1", {31'd0, q_hazard1}, {31'd0, m_hz1});
        check("q_hazard2", {31'd0, q_hazard2}, {31'd0, m_hz2});
        check("busy", {31'd0, busy}, {31'd0, bsy});
        check("stall_cnt", {16'd0, stall_cnt}, m_stall_cnt);
        check("issue_cnt", {16'd0, issue_cnt}, m_issue_cnt);

        if (m_ready) begin
            if (m_issue_cnt < 65535) m_issue_cnt++;
            if (w) pend.push_back('{tgt: cyc + lat, rd: rd, sel: sel});
        end
        if (m_stall && m_stall_cnt < 65535) m_stall_cnt++;
        foreach (pend[i]) if (pend[i].tgt > cyc) keep.push_back(pend[i]);
        pend = keep;

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        int base;
        total = 0; bad = 0; cyc = 0; m_stall_cnt = 0; m_issue_cnt = 0;
        rst = 1'b1; issue_valid = 1'b0; issue_op = 2'd0; issue_rd = 5'd0;
        issue_regwrite = 1'b0; flush = 1'b0; q_rs1 = 5'd0; q_rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
        rst = 1'b0;

        // ALU rd5: writeback exactly one cycle later
        cycle(1'b1, 2'd0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
        check("pin_alu_ready", {31'd0, m_ready}, 32'd1);
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        check("pin_alu_wb", {25'd0, m_wbv, m_wbrd, m_wbsel}, {25'd0, 1'b1, 5'd5, 2'd0});
        check("pin_alu_cnt", m_issue_cnt, 32'd1);
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        check("pin_alu_wb_once", {31'd0, m_wbv}, 32'd0);
        idle(2);

        // VDOT rd3 then MEM rd4 collide on the same slot
        base = m_stall_cnt;
        cycle(1'b1, 2'd2, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 2'd1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0);
        check("pin_slot_reject", {30'd0, m_ready, m_stall}, 32'b01);
        cycle(1'b1, 2'd1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0);
        check("pin_slot_retry", {31'd0, m_ready}, 32'd1);
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        check("pin_vdot_wb", {25'd0, m_wbv, m_wbrd, m_wbsel}, {25'd0, 1'b1, 5'd3, 2'd2});
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        check("pin_mem_wb", {25'd0, m_wbv, m_wbrd, m_wbsel}, {25'd0, 1'b1, 5'd4, 2'd1});
        check("pin_stall_cnt", m_stall_cnt - base, 32'd1);
        idle(2);

        // WAW on rd7 then slot conflict, accepted only after VDOT reaches T[0]
        cycle(1'b1, 2'd2, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 2'd0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        check("pin_waw_reject", {31'd0, m_ready}, 32'd0);
        cycle(1'b1, 2'd0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        check("pin_waw_slot_reject", {31'd0, m_ready}, 32'd0);
        cycle(1'b1, 2'd0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        check("pin_waw_accept", {31'd0, m_ready}, 32'd1);
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        check("pin_waw_order", {25'd0, m_wbv, m_wbrd, m_wbsel}, {25'd0, 1'b1, 5'd7, 2'd0});
        idle(2);

        // RAW query on a pending MEM load
        cycle(1'b1, 2'd1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
        check("pin_hazard_pending", {30'd0, m_hz1, m_hz2}, 32'b10);
        cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
        check("pin_hazard_fwd", {31'd0, m_hz1}, 32'd0);
        idle(2);

        // flush kills the request; store after VDOT needs no slot
        cycle(1'b1, 2'd0, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
        check("pin_flush", {30'd0, m_ready, m_stall}, 32'd0);
        cycle(1'b1, 2'd2, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 2'd1, 5'd6, 1'b0, 1'b0, 5'd0, 5'd0);
        check("pin_store", {31'd0, m_ready}, 32'd1);
        idle(4);

        // async reset while a writeback is visible and a VDOT is in flight
        cycle(1'b1, 2'd0, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 2'd2, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cnts", {stall_cnt, issue_cnt}, 32'd0);
        @(posedge clk);
        cyc++;
        #1 rst = 1'b0;
        pend.delete();
        m_stall_cnt = 0;
        m_issue_cnt = 0;
        idle(5);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic       v, rw, fl;
            logic [1:0] op;
            logic [4:0] rd, qa, qb;
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 7));
            rw = ($urandom_range(0, 6) != 0);
            fl = ($urandom_range(0, 9) == 0);
            qa = 5'($urandom_range(0, 7));
            qb = 5'($urandom_range(0, 7));
            cycle(v, op, rd, rw, fl, qa, qb);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
